sha3_axis_pad_packer: RTL and testbench
=======================================

# sha3_axis_pad_packer

Upstream stage of the SHA3 AXI-Stream hashing top. Accepts a message as 16-bit AXI-Stream beats, packs them little-endian into rate-sized blocks, applies SHA3 padding (domain byte 0x06, final byte 0x80) on the last block, and hands each block to the Keccak absorb/permutation stage over a valid/ready handshake. Messages may be empty, end on an odd byte, or end exactly on a block boundary.

## Interface
- RATE_BITS, 1088: rate in bits (1088 = SHA3-256). Must be a multiple of 16.
- WORDS, RATE_BITS/16: derived, 16-bit words per block (68 at default).
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- s_tdata  in  16  message beat; byte 0 = [7:0], byte 1 = [15:8].
- s_tkeep  in  2  valid bytes; used only on TLAST beat: 2'b11, 2'b01 or 2'b00 (empty). 2'b10 is illegal.
- s_tlast  in  1  last beat of message.
- s_tid  in  2  message ID; sampled on first beat of each message.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  beat accepted when s_tvalid & s_tready.
- blk_data  out  RATE_BITS  block; word k at [16k+15:16k].
- blk_last  out  1  block is final (padded) block of message.
- blk_id  out  2  s_tid latched for current message.
- blk_valid  out  1  block valid; held with stable data until accepted.
- blk_ready  in  1  downstream accepts block when blk_valid & blk_ready.

## Operation
- States: FILL, OUT, EXTRA.
- FILL: s_tready=1. Each accepted beat written to buffer word wcnt; wcnt increments. First beat of a message (msg_start flag set) latches s_tid into blk_id.
- Non-last beat with wcnt==WORDS-1: go to OUT, blk_last=0.
- Last beat: nbytes = 2*wcnt + popcount(keep). If nbytes < RATE_BITS/8: byte nbytes |= 0x06, byte RATE_BITS/8-1 |= 0x80 (same byte -> 0x86); go OUT with blk_last=1. If nbytes == RATE_BITS/8 (block exactly full): go OUT with blk_last=0, set pad_pending.
- Bytes after message end in final block are zero. Bytes beyond keep in last beat are zeroed, not taken from s_tdata.
- OUT: s_tready=0, blk_valid=1. On blk_ready: clear buffer, wcnt=0; if pad_pending -> EXTRA, else FILL (msg_start set if blk_last was 1).
- EXTRA: buffer = byte0 0x06, last byte 0x80, others 0; blk_last=1, blk_valid=1, s_tready=0; on blk_ready -> FILL, clear pad_pending, msg_start=1.
- wcnt width ceil(log2(WORDS+1)); never exceeds WORDS-1 in FILL.

## Timing
- Reset (ARESETn=0 at rising edge): state FILL, wcnt=0, buffer all zero, blk_valid=0, blk_last=0, blk_id=0, pad_pending=0, msg_start=1, s_tready=1 after reset. Reset mid-block or mid-OUT discards the block without handshake.
- s_tready and blk_valid are registered-state decodes; never both 1.
- Latency: block closing beat accepted at edge N -> blk_valid=1 in cycle N+1. Handshake at edge M -> s_tready=1 in cycle M+1 (FILL) or EXTRA block valid in cycle M+1.
- blk_data, blk_last, blk_id stable while blk_valid & !blk_ready.
- Throughput: one beat per cycle in FILL; one bubble cycle per block.

## Test plan
- Empty message: one beat keep=00, tlast=1 -> one block, word0=0x0006, word67=0x8000, others 0, blk_last=1.
- 16 beats 0x0001..0x0010, last keep=11 -> words0-15 = data, word16=0x0006, word67=0x8000, blk_last=1, blk_id=1.
- 3 beats, last = 0xCDAB keep=01 -> word2=0x06AB, word67=0x8000.
- 67 full beats + last 0x1234 keep=01 -> word67=0x8634 (byte135=0x86), single block.
- 68 full beats, last on 68th -> block1 data, blk_last=0; block2 word0=0x0006, word67=0x8000, blk_last=1.
- blk_ready low 5 cycles then high -> blk_data stable, s_tready=0 throughout; ARESETn pulsed mid-fill -> all outputs at reset values, next message packs from word0.

Source files
------------

// File: rtl/sha3_axis_pad_packer_if.sv
// Bus bundle between the message source and the pad/pack stage, and from the
// pad/pack stage to the Keccak absorb stage. "slave" is the packer's view:
// it sinks the message stream and sources blocks. "master" is the view of
// the surrounding logic, which sources the message stream and sinks blocks.
interface sha3_axis_pad_packer_if #(
    parameter int RATE_BITS = 1088
);
    // Message stream (16-bit AXI-Stream beats)
    logic [15:0]          s_tdata;
    logic [1:0]           s_tkeep;
    logic                 s_tlast;
    logic [1:0]           s_tid;
    logic                 s_tvalid;
    logic                 s_tready;

    // Block stream towards the permutation stage
    logic [RATE_BITS-1:0] blk_data;
    logic                 blk_last;
    logic [1:0]           blk_id;
    logic                 blk_valid;
    logic                 blk_ready;

    modport slave (
        input  s_tdata, s_tkeep, s_tlast, s_tid, s_tvalid,
        output s_tready,
        output blk_data, blk_last, blk_id, blk_valid,
        input  blk_ready
    );

    modport master (
        output s_tdata, s_tkeep, s_tlast, s_tid, s_tvalid,
        input  s_tready,
        input  blk_data, blk_last, blk_id, blk_valid,
        output blk_ready
    );
endinterface

// File: rtl/sha3_axis_pad_packer.sv
// SHA3 message packer: collects 16-bit beats little-endian into rate-sized
// blocks, applies SHA3 padding (0x06 ... 0x80) on the final block, and
// presents each block on a valid/ready handshake. A message that fills its
// last block exactly gets an extra all-padding block afterwards.
module sha3_axis_pad_packer #(
    parameter int RATE_BITS = 1088
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    sha3_axis_pad_packer_if.slave   io_bus
);
    localparam int WORDS  = RATE_BITS / 16;
    localparam int NBYTES = RATE_BITS / 8;
    localparam int WCW    = $clog2(WORDS + 1);
    localparam int NBW    = WCW + 1;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_OUT   = 2'd1,
        ST_EXTRA = 2'd2
    } state_t;

    // Block buffer held as bytes so both word writes and pad-byte ORs index it directly
    logic [NBYTES-1:0][7:0] r_buf, w_buf_next;
    logic [NBYTES-1:0][7:0] w_pad_block;
    state_t                 r_state, w_state_next;
    logic [WCW-1:0]         r_wcnt, w_wcnt_next;
    logic                   r_last, w_last_next;
    logic [1:0]             r_id, w_id_next;
    logic                   r_pad_pending, w_pad_pending_next;
    logic                   r_msg_start, w_msg_start_next;

    logic [15:0]            w_beat;
    logic [1:0]             w_popcnt;
    logic [NBW-1:0]         w_nbytes;
    logic                   w_block_full;
    logic [NBW-1:0]         w_lo_idx;
    logic [NBW-1:0]         w_hi_idx;

    // Mask the closing beat by tkeep; bytes beyond keep are zero, never s_tdata
    always_comb begin
        w_beat   = io_bus.s_tdata;
        w_popcnt = 2'd2;
        if (io_bus.s_tlast) begin
            case (io_bus.s_tkeep)
                2'b11:   begin w_beat = io_bus.s_tdata;               w_popcnt = 2'd2; end
                2'b01:   begin w_beat = {8'h00, io_bus.s_tdata[7:0]}; w_popcnt = 2'd1; end
                default: begin w_beat = 16'h0000;                     w_popcnt = 2'd0; end
            endcase
        end
    end

    assign w_lo_idx     = {r_wcnt, 1'b0};
    assign w_hi_idx     = {r_wcnt, 1'b1};
    assign w_nbytes     = {r_wcnt, 1'b0} + NBW'(w_popcnt);
    assign w_block_full = (w_nbytes == NBW'(NBYTES));

    // Padding-only block used when the message ended exactly on a block boundary
    always_comb begin
        w_pad_block            = '0;
        w_pad_block[0]         = 8'h06;
        w_pad_block[NBYTES-1]  = w_pad_block[NBYTES-1] | 8'h80;
    end

    // Next-state and datapath update for FILL / OUT / EXTRA
    always_comb begin
        w_state_next       = r_state;
        w_buf_next         = r_buf;
        w_wcnt_next        = r_wcnt;
        w_last_next        = r_last;
        w_id_next          = r_id;
        w_pad_pending_next = r_pad_pending;
        w_msg_start_next   = r_msg_start;

        case (r_state)
            ST_FILL: begin
                if (io_bus.s_tvalid) begin
                    w_buf_next[w_lo_idx] = w_beat[7:0];
                    w_buf_next[w_hi_idx] = w_beat[15:8];
                    if (r_msg_start) begin
                        w_id_next        = io_bus.s_tid;
                        w_msg_start_next = 1'b0;
                    end
                    if (io_bus.s_tlast) begin
                        if (w_block_full) begin
                            // Padding does not fit: ship this block, pad next
                            w_last_next        = 1'b0;
                            w_pad_pending_next = 1'b1;
                        end else begin
                            // OR order makes a shared final byte come out as 0x86
                            w_buf_next[w_nbytes]   = w_buf_next[w_nbytes] | 8'h06;
                            w_buf_next[NBYTES-1]   = w_buf_next[NBYTES-1] | 8'h80;
                            w_last_next            = 1'b1;
                        end
                        w_state_next = ST_OUT;
                    end else if (r_wcnt == WCW'(WORDS - 1)) begin
                        w_last_next  = 1'b0;
                        w_state_next = ST_OUT;
                    end else begin
                        w_wcnt_next = r_wcnt + WCW'(1);
                    end
                end
            end

            ST_OUT: begin
                if (io_bus.blk_ready) begin
                    w_wcnt_next = '0;
                    if (r_pad_pending) begin
                        w_buf_next   = w_pad_block;
                        w_last_next  = 1'b1;
                        w_state_next = ST_EXTRA;
                    end else begin
                        w_buf_next       = '0;
                        w_msg_start_next = r_msg_start | r_last;
                        w_last_next      = 1'b0;
                        w_state_next     = ST_FILL;
                    end
                end
            end

            ST_EXTRA: begin
                if (io_bus.blk_ready) begin
                    w_buf_next         = '0;
                    w_wcnt_next        = '0;
                    w_pad_pending_next = 1'b0;
                    w_msg_start_next   = 1'b1;
                    w_last_next        = 1'b0;
                    w_state_next       = ST_FILL;
                end
            end

            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    // State register; reset discards any partially built or pending block
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state       <= ST_FILL;
            r_buf         <= '0;
            r_wcnt        <= '0;
            r_last        <= 1'b0;
            r_id          <= 2'd0;
            r_pad_pending <= 1'b0;
            r_msg_start   <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_buf         <= w_buf_next;
            r_wcnt        <= w_wcnt_next;
            r_last        <= w_last_next;
            r_id          <= w_id_next;
            r_pad_pending <= w_pad_pending_next;
            r_msg_start   <= w_msg_start_next;
        end
    end

    assign io_bus.s_tready  = (r_state == ST_FILL);
    assign io_bus.blk_valid = (r_state != ST_FILL);
    assign io_bus.blk_data  = r_buf;
    assign io_bus.blk_last  = r_last;
    assign io_bus.blk_id    = r_id;

endmodule

// File: tb/tb_sha3_axis_pad_packer.sv
// Scoreboard bench for the SHA3 pad/pack stage: the driver pushes the
// hand-computed expected block for each message, the monitor pops and
// compares whenever a block is presented.
module tb_sha3_axis_pad_packer;
    localparam int RB    = 1088;
    localparam int WORDS = RB / 16;

    typedef struct {
        logic [RB-1:0] data;
        logic          last;
        logic [1:0]    id;
        bit            stall;
    } exp_t;

    logic   ACLK = 1'b0;
    logic   ARESETn = 1'b0;
    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_blocks = 0;
    logic [15:0] ew [WORDS];

    sha3_axis_pad_packer_if #(.RATE_BITS(RB)) bus ();

    sha3_axis_pad_packer #(.RATE_BITS(RB)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .io_bus  (bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [RB-1:0] act, input logic [RB-1:0] exp);
        int first;
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            first = 0;
            for (int k = WORDS - 1; k >= 0; k--)
                if (act[16*k +: 16] !== exp[16*k +: 16]) first = k;
            $display("FAIL %s: word %0d got 0x%04h required 0x%04h", nm, first,
                     act[16*first +: 16], exp[16*first +: 16]);
        end
    endtask

    task automatic clr_exp();
        for (int k = 0; k < WORDS; k++) ew[k] = 16'h0000;
    endtask

    task automatic push_exp(input logic last, input logic [1:0] id, input bit stall);
        exp_t e;
        for (int k = 0; k < WORDS; k++) e.data[16*k +: 16] = ew[k];
        e.last  = last;
        e.id    = id;
        e.stall = stall;
        q.push_back(e);
    endtask

    // Drive one beat from a negedge and return at the negedge after it is accepted
    task automatic send_beat(input logic [15:0] d, input logic [1:0] keep,
                             input logic last, input logic [1:0] id);
        int n;
        bus.s_tdata  = d;
        bus.s_tkeep  = keep;
        bus.s_tlast  = last;
        bus.s_tid    = id;
        bus.s_tvalid = 1'b1;
        n = 0;
        while (!bus.s_tready && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 200) chk("s_tready_timeout", 32'(bus.s_tready), 32'd1);
        @(negedge ACLK);
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge ACLK);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Monitor: compare every presented block against the scoreboard head
    initial begin
        exp_t e;
        bus.blk_ready = 1'b0;
        forever begin
            @(negedge ACLK);
            if (ARESETn && bus.blk_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_block", 32'(bus.blk_valid), 32'd0);
                    bus.blk_ready = 1'b1;
                end else begin
                    e = q[0];
                    if (e.stall) begin
                        bus.blk_ready = 1'b0;
                        repeat (5) begin
                            chk_data("stall_data", bus.blk_data, e.data);
                            chk("stall_s_tready", 32'(bus.s_tready), 32'd0);
                            @(negedge ACLK);
                        end
                    end
                    bus.blk_ready = 1'b1;
                    chk_data("blk_data", bus.blk_data, e.data);
                    chk("blk_last", 32'(bus.blk_last), 32'(e.last));
                    chk("blk_id", 32'(bus.blk_id), 32'(e.id));
                    $display("block %0d id=%0d last=%0b word0=%04h word67=%04h", n_blocks,
                             bus.blk_id, bus.blk_last, bus.blk_data[15:0], bus.blk_data[RB-1 -: 16]);
                    n_blocks++;
                    void'(q.pop_front());
                end
            end else begin
                bus.blk_ready = 1'b0;
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_s_tready"},  32'(bus.s_tready),  32'd1);
        chk({tag, "_blk_valid"}, 32'(bus.blk_valid), 32'd0);
        chk({tag, "_blk_last"},  32'(bus.blk_last),  32'd0);
        chk({tag, "_blk_id"},    32'(bus.blk_id),    32'd0);
        chk({tag, "_blk_data0"}, 32'(|bus.blk_data), 32'd0);
    endtask

    // Stimulus: directed messages with hand-computed blocks
    initial begin
        bus.s_tdata  = 16'h0000;
        bus.s_tkeep  = 2'b00;
        bus.s_tlast  = 1'b0;
        bus.s_tid    = 2'd0;
        bus.s_tvalid = 1'b0;
        ARESETn      = 1'b0;
        repeat (3) @(negedge ACLK);
        chk_reset_state("reset");
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Empty message; data bits must be ignored
        clr_exp();
        ew[0] = 16'h0006; ew[WORDS-1] = 16'h8000;
        push_exp(1'b1, 2'd2, 1'b0);
        send_beat(16'hFFFF, 2'b00, 1'b1, 2'd2);
        wait_drain();

        // 16 full beats
        clr_exp();
        for (int i = 0; i < 16; i++) ew[i] = 16'(i + 1);
        ew[16] = 16'h0006; ew[WORDS-1] = 16'h8000;
        push_exp(1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 16; i++) send_beat(16'(i + 1), 2'b11, (i == 15), 2'd1);
        wait_drain();

        // Odd-length message; tid changes after first beat must not be taken
        clr_exp();
        ew[0] = 16'h1111; ew[1] = 16'h2222; ew[2] = 16'h06AB; ew[WORDS-1] = 16'h8000;
        push_exp(1'b1, 2'd3, 1'b0);
        send_beat(16'h1111, 2'b11, 1'b0, 2'd3);
        send_beat(16'h2222, 2'b11, 1'b0, 2'd0);
        send_beat(16'hCDAB, 2'b01, 1'b1, 2'd1);
        wait_drain();

        // 135 bytes: domain and final pad share byte 135 -> 0x86
        clr_exp();
        for (int i = 0; i < 67; i++) ew[i] = 16'(16'h0100 + i);
        ew[67] = 16'h8634;
        push_exp(1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 67; i++) send_beat(16'(16'h0100 + i), 2'b11, 1'b0, 2'd0);
        send_beat(16'h1234, 2'b01, 1'b1, 2'd0);
        wait_drain();

        // Exactly one full block, with downstream stall, then padding-only block
        clr_exp();
        for (int i = 0; i < WORDS; i++) ew[i] = 16'(16'hA000 + i);
        push_exp(1'b0, 2'd2, 1'b1);
        clr_exp();
        ew[0] = 16'h0006; ew[WORDS-1] = 16'h8000;
        push_exp(1'b1, 2'd2, 1'b0);
        for (int i = 0; i < WORDS; i++) send_beat(16'(16'hA000 + i), 2'b11, (i == WORDS - 1), 2'd2);
        wait_drain();

        // Reset mid-fill discards the partial block
        for (int i = 0; i < 5; i++) send_beat(16'(16'h7700 + i), 2'b11, 1'b0, 2'd3);
        ARESETn = 1'b0;
        @(negedge ACLK);
        chk_reset_state("midfill_reset");
        ARESETn = 1'b1;
        @(negedge ACLK);
        clr_exp();
        ew[0] = 16'h5555; ew[1] = 16'h6666; ew[2] = 16'h0006; ew[WORDS-1] = 16'h8000;
        push_exp(1'b1, 2'd1, 1'b0);
        send_beat(16'h5555, 2'b11, 1'b0, 2'd1);
        send_beat(16'h6666, 2'b11, 1'b1, 2'd1);
        wait_drain();

        repeat (3) @(negedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
